// File: rtl/mem_stage_access.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_stage_access                                             |
// | Description : MEM stage. Runs the data-memory req/ack handshake, stalls    |
// |               upstream while an access is outstanding, loads MEM/WB and    |
// |               resolves branch PCSrc. Optional: MEM_ALIGN_CHECK_EN.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_stage_access #(
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        WB,
  input  logic [2:0]        M,
  input  logic [7:0]        ALU_status,
  input  logic [DATA_W-1:0] ALU_result,
  input  logic [DATA_W-1:0] write_data,
  input  logic [4:0]        RegDst_address,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              pc_src,
  output logic [1:0]        _WB,
  output logic [DATA_W-1:0] _read_data,
  output logic [DATA_W-1:0] _ALU_result,
  output logic [4:0]        _RegDst_address,
  output logic              bus_error,
  output logic              misalign_err
);

  localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [DATA_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [1:0]          r_wb;
  logic [DATA_W-1:0]   r_read_data;
  logic [DATA_W-1:0]   r_alu_result;
  logic [4:0]          r_regdst;
  logic                r_bus_error;

  logic w_access;
  logic w_misalign;
  logic w_start;
  logic w_timeout;
  logic w_unused;

  assign w_access = M[1] | M[0];

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misalign_err;
  assign w_misalign = w_access & (ALU_result[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign_err <= 1'b0;
    else     r_misalign_err <= (r_state == S_IDLE) & w_misalign;
  end

  assign misalign_err = r_misalign_err;
`else
  assign w_misalign   = 1'b0;
  assign misalign_err = 1'b0;
`endif

  assign w_start   = (r_state == S_IDLE) & w_access & ~w_misalign;
  assign w_timeout = (r_state == S_BUSY) & ~mem_ack & (r_cnt == c_CNT_LAST);

  // Held low during reset so an access pending on the inputs cannot freeze the pipe.
  assign stall  = ~rst & (w_start | ((r_state == S_BUSY) & ~mem_ack & ~w_timeout));
  assign pc_src = M[2] & ALU_status[0];

  assign w_unused = ^ALU_status[7:1];

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (mem_ack || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_wb         <= 2'b00;
      r_read_data  <= '0;
      r_alu_result <= '0;
      r_regdst     <= 5'd0;
      r_bus_error  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bus_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_mem_addr   <= ALU_result;
            r_mem_wdata  <= write_data;
            r_mem_we     <= M[0];
            r_mem_req    <= 1'b1;
            r_cnt        <= '0;
            r_wb         <= 2'b00;
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_regdst     <= 5'd0;
          end else if (w_misalign) begin
            r_wb         <= 2'b00;
            r_read_data  <= '0;
            r_alu_result <= '0;
            r_regdst     <= 5'd0;
          end else begin
            r_wb         <= WB;
            r_read_data  <= '0;
            r_alu_result <= ALU_result;
            r_regdst     <= RegDst_address;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + 1'b1;
          if (mem_ack) begin
            r_mem_req    <= 1'b0;
            r_wb         <= WB;
            r_read_data  <= r_mem_we ? '0 : mem_rdata;
            r_alu_result <= ALU_result;
            r_regdst     <= RegDst_address;
          end else if (w_timeout) begin
            // Abandoned access: result written back as a bubble.
            r_mem_req    <= 1'b0;
            r_wb         <= 2'b00;
            r_read_data  <= '0;
            r_alu_result <= ALU_result;
            r_regdst     <= RegDst_address;
            r_bus_error  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req         = r_mem_req;
  assign mem_we          = r_mem_we;
  assign mem_addr        = r_mem_addr;
  assign mem_wdata       = r_mem_wdata;
  assign _WB             = r_wb;
  assign _read_data      = r_read_data;
  assign _ALU_result     = r_alu_result;
  assign _RegDst_address = r_regdst;
  assign bus_error       = r_bus_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_access.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_stage_access                                          |
// | Description : Directed self-checking bench for mem_stage_access.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_stage_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb;
  logic [2:0]  m;
  logic [7:0]  alu_status;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        pc_src;
  logic [1:0]  o_wb;
  logic [31:0] o_read_data;
  logic [31:0] o_alu_result;
  logic [4:0]  o_rd;
  logic        bus_error;
  logic        misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_access #(.DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .WB(wb), .M(m), .ALU_status(alu_status),
    .ALU_result(alu_result), .write_data(write_data), .RegDst_address(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall(stall), .pc_src(pc_src),
    ._WB(o_wb), ._read_data(o_read_data), ._ALU_result(o_alu_result),
    ._RegDst_address(o_rd), .bus_error(bus_error), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wb = 2'b00; m = 3'b000; alu_status = 8'h00; alu_result = 32'h0;
    write_data = 32'h0; rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
    step(); step();
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_wb", {30'd0, o_wb}, 32'd0);
    rst = 1'b0;

    // R-type pass-through
    wb = 2'b10; m = 3'b000; alu_result = 32'h1234; rd = 5'd7;
    #1 chk("rtype_stall", {31'd0, stall}, 32'd0);
    step();
    chk("rtype_wb", {30'd0, o_wb}, 32'h2);
    chk("rtype_alu", o_alu_result, 32'h1234);
    chk("rtype_rd", {27'd0, o_rd}, 32'd7);
    chk("rtype_rdata", o_read_data, 32'h0);

    // Branch resolution
    m = 3'b100; alu_status = 8'h01;
    #1 chk("pcsrc_taken", {31'd0, pc_src}, 32'd1);
    alu_status = 8'hFE;
    #1 chk("pcsrc_not_taken", {31'd0, pc_src}, 32'd0);
    alu_status = 8'h00;

    // Load, ack on third BUSY cycle
    wb = 2'b11; m = 3'b010; alu_result = 32'h100; rd = 5'd5;
    #1 chk("ld_stall_idle", {31'd0, stall}, 32'd1);
    chk("ld_req_idle", {31'd0, mem_req}, 32'd0);
    step();
    chk("ld_req", {31'd0, mem_req}, 32'd1);
    chk("ld_we", {31'd0, mem_we}, 32'd0);
    chk("ld_addr1", mem_addr, 32'h100);
    chk("ld_bubble_wb", {30'd0, o_wb}, 32'd0);
    chk("ld_stall_b1", {31'd0, stall}, 32'd1);
    step();
    chk("ld_stall_b2", {31'd0, stall}, 32'd1);
    chk("ld_addr2", mem_addr, 32'h100);
    step();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1 chk("ld_stall_ack", {31'd0, stall}, 32'd0);
    chk("ld_addr3", mem_addr, 32'h100);
    step();
    mem_ack = 1'b0; m = 3'b000; wb = 2'b00; alu_result = 32'h0; rd = 5'd0;
    chk("ld_req_done", {31'd0, mem_req}, 32'd0);
    chk("ld_rdata", o_read_data, 32'hDEADBEEF);
    chk("ld_wb", {30'd0, o_wb}, 32'h3);
    chk("ld_alu", o_alu_result, 32'h100);
    chk("ld_rd", {27'd0, o_rd}, 32'd5);

    // Stray ack while idle is ignored
    mem_ack = 1'b1; mem_rdata = 32'h0BAD0BAD;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_req", {31'd0, mem_req}, 32'd0);
    chk("idle_ack_rdata", o_read_data, 32'h0);

    // Store with both MemRead and MemWrite set: write wins; ack in first BUSY cycle
    wb = 2'b00; m = 3'b011; alu_result = 32'h40; write_data = 32'hA5A5A5A5; rd = 5'd2;
    #1 chk("st_stall_idle", {31'd0, stall}, 32'd1);
    step();
    chk("st_req", {31'd0, mem_req}, 32'd1);
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_addr", mem_addr, 32'h40);
    chk("st_wdata", mem_wdata, 32'hA5A5A5A5);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    #1 chk("st_stall_ack", {31'd0, stall}, 32'd0);
    step();
    mem_ack = 1'b0; m = 3'b000;
    chk("st_req_done", {31'd0, mem_req}, 32'd0);
    chk("st_rdata_zero", o_read_data, 32'h0);
    chk("st_alu", o_alu_result, 32'h40);

    // Timeout after four BUSY cycles, late ack ignored
    wb = 2'b11; m = 3'b010; alu_result = 32'h80; rd = 5'd9;
    step();
    chk("to_req", {31'd0, mem_req}, 32'd1);
    chk("to_stall_b1", {31'd0, stall}, 32'd1);
    step();
    chk("to_stall_b2", {31'd0, stall}, 32'd1);
    step();
    chk("to_stall_b3", {31'd0, stall}, 32'd1);
    step();
    chk("to_stall_b4", {31'd0, stall}, 32'd0);
    chk("to_berr_early", {31'd0, bus_error}, 32'd0);
    step();
    m = 3'b000; mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    chk("to_berr", {31'd0, bus_error}, 32'd1);
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_wb", {30'd0, o_wb}, 32'd0);
    chk("to_rdata", o_read_data, 32'h0);
    chk("to_alu", o_alu_result, 32'h80);
    chk("to_rd", {27'd0, o_rd}, 32'd9);
    #1 chk("to_stall_after", {31'd0, stall}, 32'd0);
    step();
    mem_ack = 1'b0;
    chk("to_berr_pulse", {31'd0, bus_error}, 32'd0);
    chk("to_late_ack_req", {31'd0, mem_req}, 32'd0);

    // Misaligned load at 0x42
    wb = 2'b11; m = 3'b010; alu_result = 32'h42; rd = 5'd3;
`ifdef MEM_ALIGN_CHECK_EN
    #1 chk("mis_stall", {31'd0, stall}, 32'd0);
    step();
    m = 3'b000;
    chk("mis_req", {31'd0, mem_req}, 32'd0);
    chk("mis_err", {31'd0, misalign_err}, 32'd1);
    chk("mis_wb", {30'd0, o_wb}, 32'd0);
    step();
    chk("mis_err_pulse", {31'd0, misalign_err}, 32'd0);
`else
    #1 chk("mis_stall", {31'd0, stall}, 32'd1);
    step();
    chk("mis_req", {31'd0, mem_req}, 32'd1);
    chk("mis_addr", mem_addr, 32'h42);
    chk("mis_err", {31'd0, misalign_err}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h00000055;
    step();
    mem_ack = 1'b0; m = 3'b000;
    chk("mis_rdata", o_read_data, 32'h55);
`endif

    // Reset asserted mid-BUSY abandons the access
    wb = 2'b11; m = 3'b010; alu_result = 32'h200; rd = 5'd4;
    step();
    chk("rb_req", {31'd0, mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rb_req_drop", {31'd0, mem_req}, 32'd0);
    chk("rb_stall", {31'd0, stall}, 32'd0);
    chk("rb_addr", mem_addr, 32'h0);
    chk("rb_wb", {30'd0, o_wb}, 32'd0);
    chk("rb_alu", o_alu_result, 32'h0);
    chk("rb_rd", {27'd0, o_rd}, 32'd0);
    chk("rb_rdata", o_read_data, 32'h0);
    step();
    m = 3'b000; wb = 2'b01; alu_result = 32'h77; rd = 5'd1;
    rst = 1'b0;
    step();
    chk("rb_after_req", {31'd0, mem_req}, 32'd0);
    chk("rb_after_wb", {30'd0, o_wb}, 32'h1);
    chk("rb_after_alu", o_alu_result, 32'h77);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
